avalon_ram_slave: RTL and testbench
===================================

# avalon_ram_slave

Synthesisable Avalon memory-mapped slave (responder) that serves the CPU's bus master for instruction fetch and data load/store. It holds a word-addressed RAM and completes each read or write after a fixed, parameterised number of `waitrequest` stall cycles. A side-band preload port fills program words before or during execution.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 1: stall cycles per transfer. Legal range is 1..15; 0 is illegal.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  32  byte address from the master.
  - Word index is `address[DEPTH_LOG2+1:2]`.
  - `address[1:0]` and all upper bits are ignored.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  per-byte write enable; bit n covers `writedata[8n+7:8n]`.
- `waitrequest`  out  1  slave stall; combinational from request and wait counter.
- `readdata`  out  32  registered read data.
- `inst_input`  in  1  preload enable.
- `inst_addr`  in  DEPTH_LOG2  preload word index.
- `instruction`  in  32  preload word.

## Operation
- Wait counter `cnt` (4 bits) has two states:
  - IDLE/STALL: `cnt < WAIT_CYCLES`.
  - READY: `cnt == WAIT_CYCLES`.
- `waitrequest = (read | write) & (cnt != WAIT_CYCLES)`. With no request, `waitrequest` is 0.
- Counter rules at each rising edge:
  - Request asserted and `cnt < WAIT_CYCLES`: `cnt` increments.
  - Request asserted and `cnt == WAIT_CYCLES`: the transfer completes and `cnt` returns to 0.
  - No request: `cnt` returns to 0. A master withdrawing mid-stall aborts the transfer with no side effects.
- Read path:
  - Every stall edge with `read` high and `write` low loads `readdata <= mem[index]`.
  - `readdata` holds its value otherwise, including after completion, until the next read stall edge.
- Write path:
  - On the completing edge, each byte with `byteenable[n]=1` is written.
  - Bytes with `byteenable[n]=0` are unchanged.
  - `byteenable=0000` completes the handshake but modifies nothing.
- `read` and `write` both high: treated as a write; `readdata` is not updated.
- Preload: on any rising edge with `inst_input=1`, `mem[inst_addr] <= instruction` (full word). This is independent of the bus handshake.
- Collision: if a preload and a completing bus write target the same word on the same edge, the preload wins entirely.
- A read stall sampling a word on the edge it is preloaded captures the old value.
- `address`, `writedata` and `byteenable` must be held stable while `waitrequest=1`. The slave re-samples the address each stall edge and does not latch it.
- RAM contents are not initialised and not affected by reset. Reads of never-written words return X in simulation.

## Timing
- Reset (`reset=0`, asynchronous):
  - `cnt` goes to 0 and `readdata` goes to 32'h0 immediately.
  - While reset is low, `cnt` stays 0 and no write or preload commits. `waitrequest` still equals `read|write`.
  - After `reset` rises, the first edge is a normal stall edge.
- Reset asserted mid-transfer aborts the transfer; no partial write occurs.
- Transfer latency with a request asserted in cycle 0:
  - `waitrequest` is 1 in cycles 0..WAIT_CYCLES-1 and 0 in cycle WAIT_CYCLES.
  - Completion happens at the end of cycle WAIT_CYCLES, so each transfer takes WAIT_CYCLES+1 cycles.
  - Read data is valid throughout cycle WAIT_CYCLES.
- Back-to-back: a request held asserted in the cycle after completion starts a new transfer with `waitrequest=1` (`cnt=0`). Throughput is one transfer per WAIT_CYCLES+1 cycles.
- Preload write latency is one edge; the word is visible to a read stall edge one cycle later.

## Test plan
- Reset values:
  - Hold `reset=0` with `read=1` → `readdata=0`, `waitrequest=1`.
  - Release reset; read word 0 after preloading 32'h240C0010 at `inst_addr=0` → `waitrequest` 1 for one cycle then 0, `readdata=32'h240C0010`.
- Preload then fetch: preload words 1..5 with 32'h08000005, 32'h24420020, 32'h24420030, 32'h24420040, 32'h00000008; read addresses 0x04..0x14 back-to-back → each returns its word after exactly 2 cycles; `address[1:0]=2'b11` returns the same data.
- Byte enables: word 3 = 32'hAABBCCDD; write 32'h11223344 with `byteenable=4'b0101` → subsequent read returns 32'hAA22CC44.
- `WAIT_CYCLES=3`: a read holds `waitrequest=1` for exactly 3 cycles. Dropping `read` after 2 cycles → no completion and `cnt` returns to 0. A following write of 32'h70 with the request held completes on the 4th cycle, and readback gives 32'h70.
- Collision: a bus write of 32'hFFFFFFFF and a preload of 32'h12345678 to word 7 on the same edge → word 7 reads 32'h12345678.
- Mid-transfer reset: pulse `reset=0` during the stall of a write to word 2 holding 32'h1 → word 2 still reads 32'h1 and `readdata` returns to 0 asynchronously.

Source files
------------

// File: rtl/avalon_ram_slave.sv
// Avalon-MM word-addressed RAM slave with a fixed number of waitrequest stall cycles
// per transfer and a side-band full-word preload port that wins over bus writes.
module avalon_ram_slave #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  inst_input,
    input  logic [DEPTH_LOG2-1:0] inst_addr,
    input  logic [31:0]           instruction
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_DONE = 4'(WAIT_CYCLES);

    logic [31:0]           mem [DEPTH];
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           readdata_q;
    logic                  req, ready, wr_commit, rd_stall;
    logic [DEPTH_LOG2-1:0] index;
    logic                  unused_addr_bits;

    assign index            = address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{address[31:DEPTH_LOG2+2], address[1:0]};
    assign readdata         = readdata_q;

    // Handshake decode and wait-counter next state; no request or completion clears it.
    always_comb begin
        req         = read | write;
        ready       = (cnt_q == CNT_DONE);
        waitrequest = req & ~ready;
        wr_commit   = write & ready;
        rd_stall    = read & ~write & ~ready;
        cnt_d       = 4'd0;
        if (req && !ready) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= 4'd0;
            readdata_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
            if (rd_stall) begin
                readdata_q <= mem[index];
            end
        end
    end

    // RAM is not reset; the preload assignment comes last so it overrides a same-word bus write.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (wr_commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        mem[index][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            if (inst_input) begin
                mem[inst_addr] <= instruction;
            end
        end
    end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed bench for avalon_ram_slave: one instance with WAIT_CYCLES=1, one with 3,
// read expectations go through a scoreboard queue popped at each completion.
module tb_avalon_ram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, writedata, instruction;
    logic [3:0]  be;
    logic        inst_input;
    logic [9:0]  inst_addr;
    logic        rd1, wr1, rd3, wr3;
    logic        wait1, wait3;
    logic [31:0] rdata1, rdata3;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prog [6] = '{32'h240C0010, 32'h08000005, 32'h24420020,
                              32'h24420030, 32'h24420040, 32'h00000008};

    always #5 clk = ~clk;

    avalon_ram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .read(rd1), .write(wr1),
        .writedata(writedata), .byteenable(be), .waitrequest(wait1), .readdata(rdata1),
        .inst_input(inst_input), .inst_addr(inst_addr), .instruction(instruction)
    );

    avalon_ram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .address(address), .read(rd3), .write(wr3),
        .writedata(writedata), .byteenable(be), .waitrequest(wait3), .readdata(rdata3),
        .inst_input(inst_input), .inst_addr(inst_addr), .instruction(instruction)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        inst_input  = 1'b1;
        inst_addr   = a;
        instruction = d;
        @(posedge clk);
        #1;
        inst_input = 1'b0;
    endtask

    // One bus transfer; for reads 'data' is the expected word, for writes it is writedata.
    task automatic xfer(input bit sel3, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] bytes, input string tag);
        int          n;
        bit          done;
        logic [31:0] exp;
        address   = addr;
        writedata = data;
        be        = bytes;
        if (!is_wr) exp_q.push_back(data);
        if (sel3) begin
            rd3 = !is_wr;
            wr3 = is_wr;
        end else begin
            rd1 = !is_wr;
            wr1 = is_wr;
        end
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((sel3 ? wait3 : wait1) == 1'b0) done = 1'b1;
            else n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(n), sel3 ? 32'd3 : 32'd1);
        if (!is_wr) begin
            exp = exp_q.pop_front();
            check({tag, "_data"}, sel3 ? rdata3 : rdata1, exp);
        end
        @(posedge clk);
        #1;
        rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; address = 32'h0; writedata = 32'h0; be = 4'h0;
        inst_input = 1'b0; inst_addr = 10'd0; instruction = 32'h0;
        rd1 = 1'b1; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;

        // Reset held with a read pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_wait", 32'(wait1), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd1   = 1'b0;

        preload(10'd0, prog[0]);
        xfer(1'b0, 1'b0, 32'h0, prog[0], 4'h0, "boot");

        // Program preload and back-to-back fetch, including ignored address bits
        for (int i = 1; i < 6; i++) preload(10'(i), prog[i]);
        for (int i = 1; i < 6; i++) xfer(1'b0, 1'b0, 32'(4 * i), prog[i], 4'h0, "fetch");
        xfer(1'b0, 1'b0, 32'h0000_0007, prog[1], 4'h0, "alias_lo");
        xfer(1'b0, 1'b0, 32'hFFFF_F013, prog[4], 4'h0, "alias_hi");

        // Byte enables
        xfer(1'b0, 1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, "be_full");
        xfer(1'b0, 1'b1, 32'h0C, 32'h11223344, 4'b0101, "be_0101");
        xfer(1'b0, 1'b0, 32'h0C, 32'hAA22CC44, 4'h0, "be_rb");
        xfer(1'b0, 1'b1, 32'h0C, 32'hDEADBEEF, 4'h0, "be_none");
        xfer(1'b0, 1'b0, 32'h0F, 32'hAA22CC44, 4'h0, "be_none_rb");

        // Read and write together behave as a write and leave readdata alone
        address = 32'h18; writedata = 32'h66; be = 4'hF; rd1 = 1'b1; wr1 = 1'b1;
        @(negedge clk);
        check("both_wait0", 32'(wait1), 32'd1);
        @(negedge clk);
        check("both_wait1", 32'(wait1), 32'd0);
        check("both_rdata", rdata1, 32'hAA22CC44);
        @(posedge clk);
        #1;
        rd1 = 1'b0; wr1 = 1'b0;
        xfer(1'b0, 1'b0, 32'h18, 32'h66, 4'h0, "both_rb");

        // Preload collides with a completing bus write to word 7
        address = 32'h1C; writedata = 32'hFFFFFFFF; be = 4'hF; wr1 = 1'b1;
        @(posedge clk);
        #1;
        inst_input = 1'b1; inst_addr = 10'd7; instruction = 32'h12345678;
        @(negedge clk);
        check("coll_wait", 32'(wait1), 32'd0);
        @(posedge clk);
        #1;
        wr1 = 1'b0; inst_input = 1'b0;
        xfer(1'b0, 1'b0, 32'h1C, 32'h12345678, 4'h0, "coll_rb");

        // Reset in the middle of a write stall
        xfer(1'b0, 1'b1, 32'h08, 32'h1, 4'hF, "mr_init");
        xfer(1'b0, 1'b0, 32'h08, 32'h1, 4'h0, "mr_pre");
        address = 32'h08; writedata = 32'hFFFFFFFF; be = 4'hF; wr1 = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mr_async", rdata1, 32'h0);
        @(negedge clk);
        check("mr_wait", 32'(wait1), 32'd1);
        @(posedge clk);
        #1;
        wr1 = 1'b0; reset = 1'b1;
        xfer(1'b0, 1'b0, 32'h08, 32'h1, 4'h0, "mr_rb");

        // WAIT_CYCLES=3: full read, aborted read, aborted write, then a held write
        xfer(1'b1, 1'b0, 32'h04, prog[1], 4'h0, "w3_read");
        address = 32'h04; rd3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("w3_abort_rd_wait", 32'(wait3), 32'd1);
        end
        @(posedge clk);
        #1;
        rd3 = 1'b0;
        @(posedge clk);
        #1;
        writedata = 32'hBAD; be = 4'hF; wr3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("w3_abort_wr_wait", 32'(wait3), 32'd1);
        end
        @(posedge clk);
        #1;
        wr3 = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b1, 1'b1, 32'h20, 32'h70, 4'hF, "w3_write");
        xfer(1'b1, 1'b0, 32'h20, 32'h70, 4'h0, "w3_rb");
        xfer(1'b1, 1'b0, 32'h04, prog[1], 4'h0, "w3_abort_rb");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
